// File: rtl/vec_ctrl_pkg.sv
// Shared definitions for the vector pipeline control block.
// Opcode constants, sequencer state encoding and opcode-class helpers.
package vec_ctrl_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpStore = 4'h8;
  localparam logic [3:0] OpSetc  = 4'hC;
  localparam logic [3:0] OpJnz   = 4'hD;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StHalted
  } state_e;

  // ALU ops (1..7) and STORE read both rA and rB.
  function automatic logic reads_regs(input logic [3:0] op);
    return (op >= 4'd1) && (op <= OpStore);
  endfunction

  // Only ALU ops write a vector register (rA).
  function automatic logic writes_reg(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per vector register.
// Ports: clk/rst (sync, active-high), set_en/set_idx marks a register pending,
// clr_en/clr_idx clears it (set wins on a same-cycle collision), rd_a_idx/rd_b_idx
// read ports returning rd_a/rd_b, any_pending ORs all bits.
module reg_scoreboard #(
  parameter int unsigned NREG = 16,
  parameter int unsigned IdxW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [IdxW-1:0] set_idx,
  input  logic            clr_en,
  input  logic [IdxW-1:0] clr_idx,
  input  logic [IdxW-1:0] rd_a_idx,
  input  logic [IdxW-1:0] rd_b_idx,
  output logic            rd_a,
  output logic            rd_b,
  output logic            any_pending
);

  logic [NREG-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    // Applied after the clear so a same-cycle set of the same register wins.
    if (set_en) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign rd_a        = pending_q[rd_a_idx];
  assign rd_b        = pending_q[rd_b_idx];
  assign any_pending = |pending_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Decode-stage control for the 4-lane vector pipeline: start/run/stall/flush/halt
// sequencing, hardware loop counter and register scoreboard hazard check.
// Ports: clk, rst (sync, active-high), start pulse, instr_d/valid_d from IF/ID,
// wb_we/wb_rd from write-back; outputs pc_en, stop, bubble, sel_pc, pc_target,
// loop_cnt, halted, busy.
module pipeline_sequencer
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned PC_W  = 12,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NREG  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      instr_d,
  input  logic             valid_d,
  input  logic             wb_we,
  input  logic [3:0]       wb_rd,
  output logic             pc_en,
  output logic             stop,
  output logic             bubble,
  output logic             sel_pc,
  output logic [PC_W-1:0]  pc_target,
  output logic [CNT_W-1:0] loop_cnt,
  output logic             halted,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] op, ra, rb;
  logic [7:0] imm8;
  logic       pend_a, pend_b, any_pending;
  logic       sb_set, sb_clr, hazard;
  logic       unused_instr;

  assign op           = instr_d[11:8];
  assign ra           = instr_d[7:4];
  assign rb           = instr_d[3:0];
  assign imm8         = instr_d[7:0];
  assign unused_instr = ^instr_d[15:12];

  // Registered pending bits only: a write-back clear is seen the following cycle.
  assign hazard = (reads_regs(op) && (pend_a || pend_b)) || ((op == OpHalt) && any_pending);
  assign sb_clr = wb_we && (state_q != StIdle) && !rst;

  reg_scoreboard #(
    .NREG (NREG),
    .IdxW (4)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (sb_set),
    .set_idx     (ra),
    .clr_en      (sb_clr),
    .clr_idx     (wb_rd),
    .rd_a_idx    (ra),
    .rd_b_idx    (rb),
    .rd_a        (pend_a),
    .rd_b        (pend_b),
    .any_pending (any_pending)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stop      = 1'b1;
    pc_en     = 1'b0;
    bubble    = 1'b1;
    sel_pc    = 1'b0;
    pc_target = '0;
    sb_set    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        stop  = 1'b0;
        pc_en = 1'b1;
        if (valid_d) begin
          if (hazard) begin
            stop  = 1'b1;
            pc_en = 1'b0;
          end else if (reads_regs(op)) begin
            bubble = 1'b0;
            sb_set = writes_reg(op);
          end else if (op == OpSetc) begin
            cnt_d = CNT_W'(imm8);
          end else if ((op == OpJnz) && (cnt_q != '0)) begin
            sel_pc    = 1'b1;
            pc_target = PC_W'(imm8);
            cnt_d     = cnt_q - CNT_W'(1);
            state_d   = StFlush;
          end else if (op == OpHalt) begin
            stop    = 1'b1;
            pc_en   = 1'b0;
            state_d = StHalted;
          end
        end
      end
      StFlush: begin
        // IF/ID holds the wrong-path instruction; it is squashed by the default bubble.
        stop    = 1'b0;
        pc_en   = 1'b1;
        state_d = StRun;
      end
      StHalted: begin
      end
      default: state_d = StIdle;
    endcase

    // Reset overrides the current state's outputs immediately.
    if (rst) begin
      stop      = 1'b1;
      pc_en     = 1'b0;
      bubble    = 1'b1;
      sel_pc    = 1'b0;
      pc_target = '0;
      sb_set    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign loop_cnt = cnt_q;
  assign halted   = (state_q == StHalted);
  assign busy     = (state_q == StRun) || (state_q == StFlush);

endmodule
